// File: rtl/diff_result_fifo_if.sv
// rtl/diff_result_fifo_if.sv - capture, show-ahead output and status bundle for diff_result_fifo
// slave is the FIFO side; master is the producer/consumer/controller side.
interface diff_result_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] difference;
  logic                  complete;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  clear_overflow;
  logic [15:0]           drop_count;

  modport slave (
    input  difference, complete, out_ready, clear_overflow,
    output out_data, out_valid, count, full, empty, overflow, drop_count
  );

  modport master (
    output difference, complete, out_ready, clear_overflow,
    input  out_data, out_valid, count, full, empty, overflow, drop_count
  );
endinterface

// File: rtl/diff_result_fifo.sv
// rtl/diff_result_fifo.sv - show-ahead FIFO buffering subtractor results, sticky drop flag
// Define DIFF_RESULT_FIFO_DROP_CNT_EN to build the saturating 16-bit dropped-push counter.
module diff_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  diff_result_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  empty, full, pop, push_ok, drop;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CNT_WIDTH'(DEPTH));
    pop        = !empty && bus.out_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    push_ok    = bus.complete && (!full || pop);
    drop       = bus.complete && full && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= bus.difference;
    end
  end

`ifdef DIFF_RESULT_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.clear_overflow) begin
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`else
  assign bus.drop_count = 16'd0;
`endif

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_diff_result_fifo.sv
// tb/tb_diff_result_fifo.sv - directed stimulus with a popped-word scoreboard for diff_result_fifo
module tb_diff_result_fifo;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   model_cnt = 0;
  logic [31:0] exp_q [$];

`ifdef DIFF_RESULT_FIFO_DROP_CNT_EN
  localparam logic [15:0] DROP_ONE = 16'd1;
`else
  localparam logic [15:0] DROP_ONE = 16'd0;
`endif

  diff_result_fifo_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) bus ();

  diff_result_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h required=none", bus.out_data);
      end else begin
        chk("pop_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  // Drives one cycle; the reference count decides whether the word should be accepted.
  task automatic cyc(input logic push, input logic [31:0] data, input logic ready, input logic clr);
    logic pop_m;
    bus.complete       = push;
    bus.difference     = data;
    bus.out_ready      = ready;
    bus.clear_overflow = clr;
    pop_m = (model_cnt > 0) && ready;
    if (push && (model_cnt < 8 || pop_m)) begin
      exp_q.push_back(data);
      model_cnt++;
    end
    if (pop_m) model_cnt--;
    @(posedge clock);
    #1;
    bus.complete       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
  endtask

  task automatic do_reset(input logic push, input logic [31:0] data);
    reset              = 1'b1;
    bus.complete       = push;
    bus.difference     = data;
    bus.out_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    @(posedge clock);
    #1;
    reset        = 1'b0;
    bus.complete = 1'b0;
    exp_q.delete();
    model_cnt = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'd0);
    chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic fill(input int first);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(first + i), 1'b0, 1'b0);
  endtask

  initial begin
    bus.difference = '0;
    bus.complete = 1'b0;
    bus.out_ready = 1'b0;
    bus.clear_overflow = 1'b0;
    do_reset(1'b0, 32'd0);

    // Reset state
    check_idle("rst");
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_drop_count", 32'(bus.drop_count), 32'd0);

    // Single push, visible next cycle, then pop
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data", bus.out_data, 32'h5);
    chk("t1_count", 32'(bus.count), 32'd1);
    chk("t1_empty", 32'(bus.empty), 32'd0);
    drain(1);
    chk("t1_empty_after", 32'(bus.empty), 32'd1);
    chk("t1_count_after", 32'(bus.count), 32'd0);

    // Fill, drop 9th, drain 1..8
    fill(1);
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd8);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("t2_overflow", 32'(bus.overflow), 32'd1);
    chk("t2_drop_count", 32'(bus.drop_count), 32'(DROP_ONE));
    chk("t2_count_after_drop", 32'(bus.count), 32'd8);
    drain(8);
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // Clear without drop, then clear coinciding with a drop
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("t5_overflow_clr", 32'(bus.overflow), 32'd0);
    chk("t5_drop_clr", 32'(bus.drop_count), 32'd0);
    fill(32'h40);
    cyc(1'b1, 32'hBEEF, 1'b0, 1'b1);
    chk("t5_overflow_set_wins", 32'(bus.overflow), 32'd1);
    chk("t5_drop_after_clr", 32'(bus.drop_count), 32'(DROP_ONE));
    drain(8);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("t5_overflow_final", 32'(bus.overflow), 32'd0);

    // Push into full FIFO while popping: accepted
    fill(1);
    cyc(1'b1, 32'h9, 1'b1, 1'b0);
    chk("t3_count", 32'(bus.count), 32'd8);
    chk("t3_overflow", 32'(bus.overflow), 32'd0);
    drain(8);
    chk("t3_empty", 32'(bus.empty), 32'd1);

    // Continuous streaming, occupancy held at one
    cyc(1'b1, 32'd100, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      cyc(1'b1, 32'(100 + i), 1'b1, 1'b0);
      chk("t4_count", 32'(bus.count), 32'd1);
      chk("t4_valid", 32'(bus.out_valid), 32'd1);
    end
    drain(1);
    chk("t4_empty", 32'(bus.empty), 32'd1);

    // Reset mid-stream while pushing 0x7
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h20 + i), 1'b0, 1'b0);
    do_reset(1'b1, 32'h7);
    check_idle("t6");
    drain(2);
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    chk("t6_head", bus.out_data, 32'h11);
    drain(2);
    check_idle("t6_end");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
